panel_pixel_fetch: RTL and testbench
====================================

# panel_pixel_fetch

Upstream feeder for the LED panel shift driver. Walks a dual-scan 64x64 framebuffer (one external synchronous-read RAM port) and emits bit-plane column data for one row pair at a time, upper- and lower-half pixels packed into the 2-bit R/G/B lanes the shift driver clocks out. Output uses a valid/ready stream, so the shift driver paces the fetch. Row and plane tags on each pixel let the driver set row select and per-plane BCM display time.

## Interface
- PANEL_WIDTH, 64: columns per row; pixels per line.
- ROW_PAIRS, 32: scanned row pairs; lower half starts at row ROW_PAIRS.
- COLOR_BITS, 4: bits per colour channel; number of bit-planes.
- ADDR_WIDTH, 12: framebuffer address width; must equal clog2(2*ROW_PAIRS*PANEL_WIDTH).
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  run request; sampled in IDLE and at line end.
- o_fb_addr  out  ADDR_WIDTH  framebuffer read address.
- o_fb_rd_en  out  1  framebuffer read strobe.
- i_fb_data  in  3*COLOR_BITS  read data, one cycle after address; {R,G,B}, R in MSBs.
- o_pix_valid  out  1  pixel word valid.
- i_pix_ready  in  1  consumer accepts pixel.
- o_pix_r / o_pix_g / o_pix_b  out  2 each  bit 0 = upper-half pixel bit, bit 1 = lower-half pixel bit, of current plane.
- o_pix_last  out  1  pixel is column PANEL_WIDTH-1 of the line.
- o_frame_end  out  1  pixel is last column, last plane, last row.
- o_line_row  out  clog2(ROW_PAIRS)  row pair of current pixel.
- o_line_plane  out  clog2(COLOR_BITS)  bit-plane of current pixel.

## Operation
- Counters: col (innermost), plane, row. Order: col 0..W-1, then plane++, col=0. After last plane: row++, plane=0. After last row: wrap to row 0 (next frame).
- Upper address = row*PANEL_WIDTH + col. Lower address = (row+ROW_PAIRS)*PANEL_WIDTH + col. Arithmetic is ADDR_WIDTH wide and never overflows for legal parameters.
- Bit extraction from each word: R = data[3C-1:2C], G = data[2C-1:C], B = data[C-1:0], where C = COLOR_BITS. Take bit [plane] of each field.
- FSM states:
  - IDLE: go to RD_UP when i_enable is high.
  - RD_UP: present upper address with rd_en=1; go to RD_LO.
  - RD_LO: present lower address with rd_en=1; capture the upper word from i_fb_data; go to CAP.
  - CAP: capture the lower word; load the pixel outputs; go to PRESENT.
  - PRESENT: o_pix_valid=1 until i_pix_ready.
- On transfer (valid && ready): advance counters.
  - If the pixel was not the line end: go to RD_UP.
  - At line end: go to RD_UP if i_enable is high, otherwise go to IDLE.
- Lowering i_enable mid-line never truncates a line.
- o_pix_last, o_frame_end, o_line_row and o_line_plane describe the presented pixel. They are stable while valid is high.

## Timing
- Reset (asynchronous, immediate): all outputs 0, state IDLE, counters 0. Reset mid-transfer drops o_pix_valid at once. There is no partial-pixel recovery; restart begins at row 0, plane 0, col 0.
- Registered outputs: o_fb_addr and o_fb_rd_en are high exactly during the RD_UP and RD_LO cycles. rd_en is 0 in IDLE, CAP and PRESENT.
- o_fb_addr holds its last value when rd_en is low.
- Latency: i_enable sampled high at edge N gives first o_pix_valid during cycle N+3 (states RD_UP, RD_LO, CAP, then PRESENT).
- Throughput: a pixel takes at least 4 cycles with ready held high. Back-to-back pixels produce valid high 1 cycle in 4.
- Backpressure: while valid is high and ready is low, all pixel outputs are held and no reads are issued.
- Ready while valid is low is ignored.
- o_frame_end is high only with the final pixel (o_pix_last=1, row=ROW_PAIRS-1, plane=COLOR_BITS-1).

## Test plan
- Reset values: hold i_rst_n=0, then release with i_enable=0. All outputs stay 0 and rd_en stays 0 for 100 cycles.
- Data packing: RAM upper half filled with 0xF0F, lower half with 0x0F0, enable=1, ready=1.
  - Reads at addresses 0 then 2048.
  - First pixel: r=2'b01, g=2'b10, b=2'b01, row=0, plane=0. The same pattern repeats on every plane.
- Plane select: word at addr 0 = 0x421, lower half 0. Plane 0: r=0, g=0, b=1. Plane 1: g=1, r=0, b=0. Plane 2: r=1, g=0, b=0. Check each plane's column-0 pixel.
- Backpressure: ready low for 10 cycles while valid is high. Outputs stay stable and o_fb_rd_en=0 throughout. Raising ready transfers exactly one pixel.
- Wrap and order: o_pix_last on transfers 64, 128, and so on. Row increments after 256 transfers. o_frame_end only on transfer 8192. The next read address is 0.
- Enable and reset mid-operation:
  - Drop enable at column 10. The line completes (64 transfers total), then IDLE.
  - Assert reset while valid is high. Valid drops immediately. After release with enable high, the first read is at address 0.

Source files
------------

// File: rtl/panel_pixel_fetch.sv
// Framebuffer walker for a dual-scan LED panel: reads the upper and lower pixel of each
// column, slices out the current bit-plane and hands packed R/G/B pairs to the shift driver.
module panel_pixel_fetch #(
  parameter int PANEL_WIDTH = 64,
  parameter int ROW_PAIRS   = 32,
  parameter int COLOR_BITS  = 4,
  parameter int ADDR_WIDTH  = 12,
  localparam int ROW_W      = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1,
  localparam int PLANE_W    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  output logic [ADDR_WIDTH-1:0]   o_fb_addr,
  output logic                    o_fb_rd_en,
  input  logic [3*COLOR_BITS-1:0] i_fb_data,
  output logic                    o_pix_valid,
  input  logic                    i_pix_ready,
  output logic [1:0]              o_pix_r,
  output logic [1:0]              o_pix_g,
  output logic [1:0]              o_pix_b,
  output logic                    o_pix_last,
  output logic                    o_frame_end,
  output logic [ROW_W-1:0]        o_line_row,
  output logic [PLANE_W-1:0]      o_line_plane
);

  localparam int COL_W = (PANEL_WIDTH > 1) ? $clog2(PANEL_WIDTH) : 1;
  localparam logic [COL_W-1:0]      COL_LAST     = COL_W'(PANEL_WIDTH - 1);
  localparam logic [PLANE_W-1:0]    PLANE_LAST   = PLANE_W'(COLOR_BITS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST     = ROW_W'(ROW_PAIRS - 1);
  localparam logic [ADDR_WIDTH-1:0] LOWER_OFFSET = ADDR_WIDTH'(ROW_PAIRS * PANEL_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] WIDTH_MUL    = ADDR_WIDTH'(PANEL_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_UP   = 3'd1,
    RD_LO   = 3'd2,
    CAP     = 3'd3,
    PRESENT = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [COL_W-1:0]        col_reg, col_next;
  logic [PLANE_W-1:0]      plane_reg, plane_next;
  logic [ROW_W-1:0]        row_reg, row_next;
  logic [ADDR_WIDTH-1:0]   fb_addr_reg, fb_addr_next;
  logic                    fb_rd_en_reg, fb_rd_en_next;
  logic [3*COLOR_BITS-1:0] up_word_reg;
  logic [1:0]              pix_r_reg, pix_g_reg, pix_b_reg;
  logic                    pix_last_reg, frame_end_reg;
  logic [ROW_W-1:0]        line_row_reg;
  logic [PLANE_W-1:0]      line_plane_reg;

  logic xfer;
  logic line_end;
  logic [ADDR_WIDTH-1:0] addr_up_calc;
  logic [COLOR_BITS-1:0] up_r, up_g, up_b, lo_r, lo_g, lo_b;

  assign xfer     = (state_reg == PRESENT) && i_pix_ready;
  assign line_end = (col_reg == COL_LAST);

  assign up_r = up_word_reg[3*COLOR_BITS-1:2*COLOR_BITS];
  assign up_g = up_word_reg[2*COLOR_BITS-1:COLOR_BITS];
  assign up_b = up_word_reg[COLOR_BITS-1:0];
  assign lo_r = i_fb_data[3*COLOR_BITS-1:2*COLOR_BITS];
  assign lo_g = i_fb_data[2*COLOR_BITS-1:COLOR_BITS];
  assign lo_b = i_fb_data[COLOR_BITS-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_enable) state_next = RD_UP;
      RD_UP:   state_next = RD_LO;
      RD_LO:   state_next = CAP;
      CAP:     state_next = PRESENT;
      PRESENT: begin
        if (i_pix_ready) begin
          // Enable is only honoured at line end so a line is never cut short.
          if (!line_end || i_enable) state_next = RD_UP;
          else                       state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    col_next   = col_reg;
    plane_next = plane_reg;
    row_next   = row_reg;
    if (xfer) begin
      if (line_end) begin
        col_next = '0;
        if (plane_reg == PLANE_LAST) begin
          plane_next = '0;
          row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          plane_next = plane_reg + 1'b1;
        end
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // Address is built from the post-transfer counters so RD_UP sees the next pixel.
  always_comb begin
    addr_up_calc  = ADDR_WIDTH'(row_next) * WIDTH_MUL + ADDR_WIDTH'(col_next);
    fb_addr_next  = fb_addr_reg;
    fb_rd_en_next = 1'b0;
    if (state_next == RD_UP) begin
      fb_addr_next  = addr_up_calc;
      fb_rd_en_next = 1'b1;
    end else if (state_next == RD_LO) begin
      fb_addr_next  = addr_up_calc + LOWER_OFFSET;
      fb_rd_en_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_reg        <= '0;
      plane_reg      <= '0;
      row_reg        <= '0;
      fb_addr_reg    <= '0;
      fb_rd_en_reg   <= 1'b0;
      up_word_reg    <= '0;
      pix_r_reg      <= '0;
      pix_g_reg      <= '0;
      pix_b_reg      <= '0;
      pix_last_reg   <= 1'b0;
      frame_end_reg  <= 1'b0;
      line_row_reg   <= '0;
      line_plane_reg <= '0;
    end else begin
      col_reg      <= col_next;
      plane_reg    <= plane_next;
      row_reg      <= row_next;
      fb_addr_reg  <= fb_addr_next;
      fb_rd_en_reg <= fb_rd_en_next;
      if (state_reg == RD_LO) begin
        up_word_reg <= i_fb_data;
      end
      if (state_reg == CAP) begin
        pix_r_reg      <= {lo_r[plane_reg], up_r[plane_reg]};
        pix_g_reg      <= {lo_g[plane_reg], up_g[plane_reg]};
        pix_b_reg      <= {lo_b[plane_reg], up_b[plane_reg]};
        pix_last_reg   <= line_end;
        frame_end_reg  <= line_end && (plane_reg == PLANE_LAST) && (row_reg == ROW_LAST);
        line_row_reg   <= row_reg;
        line_plane_reg <= plane_reg;
      end
    end
  end

  assign o_fb_addr    = fb_addr_reg;
  assign o_fb_rd_en   = fb_rd_en_reg;
  assign o_pix_valid  = (state_reg == PRESENT);
  assign o_pix_r      = pix_r_reg;
  assign o_pix_g      = pix_g_reg;
  assign o_pix_b      = pix_b_reg;
  assign o_pix_last   = pix_last_reg;
  assign o_frame_end  = frame_end_reg;
  assign o_line_row   = line_row_reg;
  assign o_line_plane = line_plane_reg;

endmodule

// File: tb/tb_panel_pixel_fetch.sv
// Scoreboard bench for panel_pixel_fetch: a frame-order model predicts every read address
// and pixel word, a negedge monitor pops and compares whatever the DUT presents.
module tb_panel_pixel_fetch;

  localparam int W = 64;
  localparam int R = 32;
  localparam int C = 4;
  localparam int AW = 12;
  localparam int FRAME = W * C * R;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_pix_ready = 1'b0;
  logic [AW-1:0] o_fb_addr;
  logic          o_fb_rd_en;
  logic [3*C-1:0] i_fb_data = '0;
  logic          o_pix_valid;
  logic [1:0]    o_pix_r, o_pix_g, o_pix_b;
  logic          o_pix_last, o_frame_end;
  logic [4:0]    o_line_row;
  logic [1:0]    o_line_plane;

  panel_pixel_fetch #(
    .PANEL_WIDTH(W), .ROW_PAIRS(R), .COLOR_BITS(C), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .o_fb_addr(o_fb_addr), .o_fb_rd_en(o_fb_rd_en), .i_fb_data(i_fb_data),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b),
    .o_pix_last(o_pix_last), .o_frame_end(o_frame_end),
    .o_line_row(o_line_row), .o_line_plane(o_line_plane)
  );

  always #5 i_clk = ~i_clk;

  logic [3*C-1:0] mem [0:(1<<AW)-1];
  always @(posedge i_clk) if (o_fb_rd_en) i_fb_data <= mem[o_fb_addr];

  typedef struct packed {
    logic [1:0] r, g, b;
    logic       last, fend;
    logic [4:0] row;
    logic [1:0] plane;
  } pix_t;

  pix_t pixq[$];
  int   addrq[$];
  int   exp_k = 0;
  int   n_xfer = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the k-th pixel since reset is col k%W, plane (k/W)%C, row (k/(W*C))%R.
  task automatic push_pixel();
    int col, plane, row, ua, la;
    logic [3*C-1:0] uw, lw;
    pix_t e;
    col   = exp_k % W;
    plane = (exp_k / W) % C;
    row   = (exp_k / (W * C)) % R;
    ua = row * W + col;
    la = (row + R) * W + col;
    uw = mem[ua];
    lw = mem[la];
    e.r     = {lw[2*C + plane], uw[2*C + plane]};
    e.g     = {lw[C + plane], uw[C + plane]};
    e.b     = {lw[plane], uw[plane]};
    e.last  = (col == W - 1);
    e.fend  = ((exp_k % FRAME) == FRAME - 1);
    e.row   = 5'(row);
    e.plane = 2'(plane);
    pixq.push_back(e);
    addrq.push_back(ua);
    addrq.push_back(la);
    exp_k++;
  endtask

  pix_t cur, prev;
  logic prev_hold = 1'b0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      cur = '{r: o_pix_r, g: o_pix_g, b: o_pix_b, last: o_pix_last, fend: o_frame_end,
              row: o_line_row, plane: o_line_plane};
      if (prev_hold) begin
        chk("hold_valid", 32'(o_pix_valid), 32'd1);
        chk("hold_outputs", 32'(cur), 32'(prev));
      end
      if (o_fb_rd_en) begin
        chk("read_expected", 32'(addrq.size() > 0), 32'd1);
        if (addrq.size() > 0) chk("read_addr", 32'(o_fb_addr), 32'(addrq.pop_front()));
      end
      if (o_pix_valid) chk("rd_en_while_valid", 32'(o_fb_rd_en), 32'd0);
      if (o_pix_valid && i_pix_ready) begin
        n_xfer++;
        chk("pixel_expected", 32'(pixq.size() > 0), 32'd1);
        if (pixq.size() > 0) chk("pixel", 32'(cur), 32'(pixq.pop_front()));
        $display("xfer %0d row %0d plane %0d r %b g %b b %b last %b fend %b",
                 n_xfer, cur.row, cur.plane, cur.r, cur.g, cur.b, cur.last, cur.fend);
      end
      prev_hold = o_pix_valid && !i_pix_ready;
      prev = cur;
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, 32'({o_fb_addr, o_fb_rd_en, o_pix_valid, o_pix_r, o_pix_g, o_pix_b,
                   o_pix_last, o_frame_end, o_line_row, o_line_plane}), 32'd0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_enable = 1'b0;
    i_pix_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    pixq.delete();
    addrq.delete();
    exp_k = 0;
    chk_all_zero("reset_outputs");
    i_rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int a = 0; a < (1 << AW); a++) mem[a] = 12'($urandom);
  endtask

  task automatic push_lines(input int lines, output int target);
    for (int i = 0; i < lines * W; i++) push_pixel();
    target = n_xfer + lines * W;
  endtask

  // Drops enable ten pixels into the final line; the line must still complete.
  task automatic drive_until(input int target, input bit rand_ready);
    int budget;
    bit done;
    budget = (target - n_xfer) * 12 + 200;
    done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(posedge i_clk);
      #1;
      if (n_xfer >= target - (W - 10)) i_enable = 1'b0;
      if (n_xfer >= target) done = 1'b1;
      else i_pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    i_pix_ready = 1'b0;
    chk("transfer_count", 32'(n_xfer), 32'(target));
  endtask

  task automatic expect_idle();
    repeat (20) @(posedge i_clk);
    #1;
    chk("idle_pending_pixels", 32'(pixq.size()), 32'd0);
    chk("idle_pending_reads", 32'(addrq.size()), 32'd0);
    chk("idle_valid", 32'(o_pix_valid), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_pix_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk(name, 32'(o_pix_valid), 32'd1);
  endtask

  initial begin
    int t;
    int base;

    // Reset hold and 100 idle cycles with enable low
    i_rst_n = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk_all_zero("reset_hold");
    i_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk);
      #1;
      chk_all_zero("reset_idle");
    end

    // Data packing: upper half 0xF0F, lower half 0x0F0
    for (int a = 0; a < (1 << AW); a++) mem[a] = (a < R * W) ? 12'hF0F : 12'h0F0;
    do_reset();
    push_lines(5, t);
    i_enable = 1'b1;
    drive_until(t, 1'b0);
    expect_idle();

    // Plane select on word 0x421 with zero lower half
    fill_random();
    for (int a = R * W; a < (1 << AW); a++) mem[a] = '0;
    mem[0] = 12'h421;
    do_reset();
    push_lines(4, t);
    i_enable = 1'b1;
    drive_until(t, 1'b1);
    expect_idle();

    // Backpressure: ten stalled cycles, then a single-cycle ready
    fill_random();
    push_lines(1, t);
    i_enable = 1'b1;
    i_pix_ready = 1'b0;
    wait_valid("bp_valid_seen");
    repeat (10) @(posedge i_clk);
    #1;
    base = n_xfer;
    i_pix_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_pix_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("bp_single_transfer", 32'(n_xfer), 32'(base + 1));
    drive_until(t, 1'b1);
    expect_idle();

    // Random backpressure over several lines
    fill_random();
    push_lines(8, t);
    i_enable = 1'b1;
    drive_until(t, 1'b1);
    expect_idle();

    // Full frame plus one line: frame_end placement and wrap to address 0
    fill_random();
    do_reset();
    push_lines(FRAME / W + 1, t);
    i_enable = 1'b1;
    drive_until(t, 1'b0);
    expect_idle();

    // Reset while a pixel is presented, then restart from the top
    fill_random();
    push_lines(1, t);
    i_enable = 1'b1;
    i_pix_ready = 1'b0;
    wait_valid("mid_valid_seen");
    i_rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", 32'(o_pix_valid), 32'd0);
    chk_all_zero("reset_mid_outputs");
    pixq.delete();
    addrq.delete();
    exp_k = 0;
    repeat (2) @(posedge i_clk);
    #1;
    push_lines(1, t);
    i_enable = 1'b1;
    i_rst_n = 1'b1;
    drive_until(t, 1'b1);
    expect_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
